// File: rtl/math_pipelined_addsub_pkg.sv
// Shared helpers for the chunked pipelined add/sub: chunk sizing arithmetic and flag bundle type.
package math_pipelined_addsub_pkg;

   typedef struct packed {
      logic cout;
      logic ovf;
   } flags_t;

   function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
      return (n + d - 1) / d;
   endfunction

endpackage

// File: rtl/math_addsub_chunk.sv
// One pipeline stage of the ripple chain: CHUNK_WIDTH-bit add whose sum and carry are registered.
module math_addsub_chunk #(
   parameter int unsigned CHUNK_WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_en,
   input  logic [CHUNK_WIDTH-1:0] i_a,
   input  logic [CHUNK_WIDTH-1:0] i_b,
   input  logic                   i_cin,
   output logic [CHUNK_WIDTH-1:0] o_sum,
   output logic                   o_cout
);

   logic [CHUNK_WIDTH:0]   w_sum;
   logic [CHUNK_WIDTH-1:0] r_sum;
   logic                   r_cout;

   assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK_WIDTH{1'b0}}, i_cin};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else if (i_en) begin
         {r_cout, r_sum} <= w_sum;
      end
   end

   assign o_sum  = r_sum;
   assign o_cout = r_cout;

endmodule

// File: rtl/math_pipelined_addsub.sv
// Fully pipelined chunked ripple-carry adder/subtractor with fixed LATENCY and valid tagging.
// Data registers only load when a valid sample passes, so outputs hold across bubbles.
module math_pipelined_addsub
   import math_pipelined_addsub_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned LATENCY = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic             in_valid,
   input  logic             in_sub,
   input  logic             in_cin,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_q,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int unsigned ALU_WIDTH       = ceil_div(WIDTH, LATENCY);
   localparam int unsigned CHUNK_COUNT     = ceil_div(WIDTH, ALU_WIDTH);
   localparam int unsigned LAST_CHUNK_SIZE = WIDTH - (CHUNK_COUNT - 1) * ALU_WIDTH;
   localparam int unsigned PAD             = LATENCY - CHUNK_COUNT;

   logic [LATENCY-1:0]     r_valid;
   logic [LATENCY-1:0]     w_en;
   logic [CHUNK_COUNT-1:0] r_sub;
   logic [CHUNK_COUNT:0]   w_carry;
   logic [WIDTH-1:0]       w_b_eff;
   logic [WIDTH-1:0]       w_q;
   logic                   w_last_a_msb, w_last_b_msb, w_last_sum_msb;
   logic                   r_a_msb, r_b_msb;
   flags_t                 w_flags, w_flags_out;

   assign w_b_eff    = in_b ^ {WIDTH{in_sub}};
   assign w_carry[0] = in_cin ^ in_sub;

   // Stage s loads only when the sample entering it is valid.
   always_comb begin
      w_en[0] = ce & in_valid;
      for (int s = 1; s < LATENCY; s++) begin
         w_en[s] = ce & r_valid[s-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_sub   <= '0;
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
      end else begin
         if (ce) begin
            r_valid[0] <= in_valid;
            for (int s = 1; s < LATENCY; s++) begin
               r_valid[s] <= r_valid[s-1];
            end
         end
         if (w_en[0]) r_sub[0] <= in_sub;
         for (int s = 1; s < CHUNK_COUNT; s++) begin
            if (w_en[s]) r_sub[s] <= r_sub[s-1];
         end
         if (w_en[CHUNK_COUNT-1]) begin
            r_a_msb <= w_last_a_msb;
            r_b_msb <= w_last_b_msb;
         end
      end
   end

   for (genvar k = 0; k < CHUNK_COUNT; k++) begin : g_chunk
      localparam int unsigned CW  = (k == CHUNK_COUNT - 1) ? LAST_CHUNK_SIZE : ALU_WIDTH;
      localparam int unsigned LO  = k * ALU_WIDTH;
      localparam int unsigned DSK = LATENCY - 1 - k;

      logic [CW-1:0] w_a, w_b, w_sum;

      if (k == 0) begin : g_direct
         assign w_a = in_a[LO +: CW];
         assign w_b = w_b_eff[LO +: CW];
      end else begin : g_skew
         logic [CW-1:0] r_a [k];
         logic [CW-1:0] r_b [k];

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int j = 0; j < k; j++) begin
                  r_a[j] <= '0;
                  r_b[j] <= '0;
               end
            end else begin
               if (w_en[0]) begin
                  r_a[0] <= in_a[LO +: CW];
                  r_b[0] <= w_b_eff[LO +: CW];
               end
               for (int j = 1; j < k; j++) begin
                  if (w_en[j]) begin
                     r_a[j] <= r_a[j-1];
                     r_b[j] <= r_b[j-1];
                  end
               end
            end
         end

         assign w_a = r_a[k-1];
         assign w_b = r_b[k-1];
      end

      math_addsub_chunk #(
         .CHUNK_WIDTH(CW)
      ) u_chunk (
         .clk   (clk),
         .rst_n (rst_n),
         .i_en  (w_en[k]),
         .i_a   (w_a),
         .i_b   (w_b),
         .i_cin (w_carry[k]),
         .o_sum (w_sum),
         .o_cout(w_carry[k+1])
      );

      if (DSK == 0) begin : g_nodeskew
         assign w_q[LO +: CW] = w_sum;
      end else begin : g_deskew
         logic [CW-1:0] r_d [DSK];

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int j = 0; j < DSK; j++) r_d[j] <= '0;
            end else begin
               if (w_en[k+1]) r_d[0] <= w_sum;
               for (int j = 1; j < DSK; j++) begin
                  if (w_en[k+1+j]) r_d[j] <= r_d[j-1];
               end
            end
         end

         assign w_q[LO +: CW] = r_d[DSK-1];
      end

      if (k == CHUNK_COUNT - 1) begin : g_msb
         assign w_last_a_msb   = w_a[CW-1];
         assign w_last_b_msb   = w_b[CW-1];
         assign w_last_sum_msb = w_sum[CW-1];
      end
   end

   assign w_flags.cout = r_sub[CHUNK_COUNT-1] ^ w_carry[CHUNK_COUNT];
   assign w_flags.ovf  = (r_a_msb == r_b_msb) && (w_last_sum_msb != r_a_msb);

   if (PAD == 0) begin : g_nopad
      assign w_flags_out = w_flags;
   end else begin : g_pad
      flags_t r_fd [PAD];

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int j = 0; j < PAD; j++) r_fd[j] <= '0;
         end else begin
            if (w_en[CHUNK_COUNT]) r_fd[0] <= w_flags;
            for (int j = 1; j < PAD; j++) begin
               if (w_en[CHUNK_COUNT+j]) r_fd[j] <= r_fd[j-1];
            end
         end
      end

      assign w_flags_out = r_fd[PAD-1];
   end

   assign out_valid = r_valid[LATENCY-1];
   assign out_q     = w_q;
   assign out_cout  = w_flags_out.cout;
   assign out_ovf   = w_flags_out.ovf;

endmodule

// File: tb/tb_math_pipelined_addsub.sv
// Bench: five parameterisations driven in parallel, each compared every cycle against a
// history-based reference model; plus directed vectors and latency/stall/reset sequences.
module tb_math_pipelined_addsub;

   localparam int ND = 5;
   localparam int HN = 4096;
   localparam int W_T [ND] = '{8, 7, 5, 8, 16};
   localparam int L_T [ND] = '{4, 3, 4, 1, 16};

   typedef struct {
      logic       sub;
      logic       cin;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic       cout;
      logic       ovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n, ce, in_valid, in_sub, in_cin;
   logic [15:0] a16, b16;

   logic [ND-1:0] ov, oc, oo;
   logic [7:0]    q0;
   logic [6:0]    q1;
   logic [4:0]    q2;
   logic [7:0]    q3;
   logic [15:0]   q4;
   logic [15:0]   oq [ND];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic        h_v [HN];
   logic        h_s [HN];
   logic        h_c [HN];
   logic [15:0] h_a [HN];
   logic [15:0] h_b [HN];
   int          e_cnt  = 0;
   int          e_base = 0;
   bit          armed  = 0;
   logic        e_v [ND];
   logic [15:0] e_q [ND];
   logic        e_c [ND];
   logic        e_o [ND];

   always #5 clk = ~clk;

   math_pipelined_addsub #(.WIDTH(8), .LATENCY(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_sub(in_sub), .in_cin(in_cin),
      .in_a(a16[7:0]), .in_b(b16[7:0]),
      .out_valid(ov[0]), .out_q(q0), .out_cout(oc[0]), .out_ovf(oo[0]));
   math_pipelined_addsub #(.WIDTH(7), .LATENCY(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_sub(in_sub), .in_cin(in_cin),
      .in_a(a16[6:0]), .in_b(b16[6:0]),
      .out_valid(ov[1]), .out_q(q1), .out_cout(oc[1]), .out_ovf(oo[1]));
   math_pipelined_addsub #(.WIDTH(5), .LATENCY(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_sub(in_sub), .in_cin(in_cin),
      .in_a(a16[4:0]), .in_b(b16[4:0]),
      .out_valid(ov[2]), .out_q(q2), .out_cout(oc[2]), .out_ovf(oo[2]));
   math_pipelined_addsub #(.WIDTH(8), .LATENCY(1)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_sub(in_sub), .in_cin(in_cin),
      .in_a(a16[7:0]), .in_b(b16[7:0]),
      .out_valid(ov[3]), .out_q(q3), .out_cout(oc[3]), .out_ovf(oo[3]));
   math_pipelined_addsub #(.WIDTH(16), .LATENCY(16)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_sub(in_sub), .in_cin(in_cin),
      .in_a(a16), .in_b(b16),
      .out_valid(ov[4]), .out_q(q4), .out_cout(oc[4]), .out_ovf(oo[4]));

   assign oq[0] = 16'(q0);
   assign oq[1] = 16'(q1);
   assign oq[2] = 16'(q2);
   assign oq[3] = 16'(q3);
   assign oq[4] = q4;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Plain integer arithmetic on the mathematical values of the operands.
   function automatic void model(input logic sub, input logic cin, input logic [15:0] a,
                                 input logic [15:0] b, input int w, output logic [15:0] q,
                                 output logic co, output logic ovf);
      longint mask, half, ua, ub, sa, sb, r, sr, c;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua   = longint'(a) & mask;
      ub   = longint'(b) & mask;
      sa   = (ua >= half) ? ua - 2 * half : ua;
      sb   = (ub >= half) ? ub - 2 * half : ub;
      c    = longint'(cin);
      if (!sub) begin
         r  = ua + ub + c;
         co = (r > mask);
         sr = sa + sb + c;
      end else begin
         r  = ua - ub - c;
         co = (r < 0);
         sr = sa - sb - c;
      end
      q   = 16'(r & mask);
      ovf = (sr >= half) || (sr < -half);
   endfunction

   // Each DUT's output after an enabled edge is the sample accepted LATENCY-1 enabled edges earlier.
   always @(posedge clk) begin
      if (!rst_n) begin
         e_base = e_cnt;
         armed  = 1;
         for (int d = 0; d < ND; d++) begin
            e_v[d] = 0; e_q[d] = '0; e_c[d] = 0; e_o[d] = 0;
         end
      end else if (ce) begin
         h_v[e_cnt % HN] = in_valid;
         h_s[e_cnt % HN] = in_sub;
         h_c[e_cnt % HN] = in_cin;
         h_a[e_cnt % HN] = a16;
         h_b[e_cnt % HN] = b16;
         for (int d = 0; d < ND; d++) begin
            int          idx;
            logic [15:0] mq;
            logic        mc, mo;
            idx = e_cnt - (L_T[d] - 1);
            if (idx >= e_base && h_v[idx % HN]) begin
               model(h_s[idx % HN], h_c[idx % HN], h_a[idx % HN], h_b[idx % HN], W_T[d],
                     mq, mc, mo);
               e_v[d] = 1; e_q[d] = mq; e_c[d] = mc; e_o[d] = mo;
            end else begin
               e_v[d] = 0;
            end
         end
         e_cnt++;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         for (int d = 0; d < ND; d++) begin
            chk($sformatf("model_valid dut%0d", d), 32'(ov[d]), 32'(e_v[d]));
            chk($sformatf("model_q dut%0d", d), 32'(oq[d]), 32'(e_q[d]));
            chk($sformatf("model_cout dut%0d", d), 32'(oc[d]), 32'(e_c[d]));
            chk($sformatf("model_ovf dut%0d", d), 32'(oo[d]), 32'(e_o[d]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!ov[0] && n < 40) begin
         step();
         n++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [6];
      logic [12:0] vseen;
      int          n, cnt;

      tbl[0] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
      tbl[4] = '{1'b1, 1'b1, 8'h05, 8'h03, 8'h01, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 8'h80, 8'h80, 8'h01, 1'b1, 1'b1};

      rst_n = 0; ce = 0; in_valid = 0; in_sub = 0; in_cin = 0; a16 = '0; b16 = '0;
      step();
      step();
      chk("reset_valid", 32'(ov[0]), 0);
      chk("reset_q", 32'(q0), 0);
      chk("reset_flags", {oc[0], oo[0]}, 0);
      rst_n = 1; ce = 1;

      // directed vectors, exact latency on the 8/4 instance
      for (int i = 0; i < 6; i++) begin
         in_valid = 1; in_sub = tbl[i].sub; in_cin = tbl[i].cin;
         a16 = {8'h00, tbl[i].a}; b16 = {8'h00, tbl[i].b};
         step();
         in_valid = 0;
         step();
         step();
         chk($sformatf("dir%0d_early_valid", i), 32'(ov[0]), 0);
         step();
         chk($sformatf("dir%0d_valid", i), 32'(ov[0]), 1);
         chk($sformatf("dir%0d_q", i), 32'(q0), 32'(tbl[i].q));
         chk($sformatf("dir%0d_cout", i), 32'(oc[0]), 32'(tbl[i].cout));
         chk($sformatf("dir%0d_ovf", i), 32'(oo[0]), 32'(tbl[i].ovf));
      end

      // back-to-back stream of 8, alternating add/sub
      for (int i = 0; i < 13; i++) begin
         if (i < 8) begin
            in_valid = 1; in_sub = i[0]; in_cin = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom);
         end else begin
            in_valid = 0;
         end
         step();
         vseen[i] = ov[0];
      end
      chk("stream_valid_pattern", 32'(vseen), 32'h7F8);

      // single sample with a 3-cycle stall right after acceptance
      in_valid = 1; in_sub = 0; in_cin = 0; a16 = 16'h0012; b16 = 16'h0034;
      step();
      in_valid = 0; ce = 0;
      repeat (3) step();
      ce = 1;
      wait_valid(n);
      chk("stall_latency", 32'(n + 3), 6);
      repeat (4) step();

      // mixed stream: bubbles and a mid-stream stall, checked by the model
      for (int i = 0; i < 12; i++) begin
         ce       = !(i >= 4 && i < 7);
         in_valid = (i % 3) != 1;
         in_sub   = 1'($urandom); in_cin = 1'($urandom);
         a16 = 16'($urandom); b16 = 16'($urandom);
         step();
      end
      ce = 1; in_valid = 0;
      repeat (20) step();

      // reset with three samples in flight, ce low in the same cycle
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_sub = 1'(i); in_cin = 0; a16 = 16'($urandom); b16 = 16'($urandom);
         step();
      end
      rst_n = 0; ce = 0;
      step();
      rst_n = 1; ce = 1; in_valid = 0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         cnt += int'(ov[0]);
      end
      chk("post_reset_no_valid", 32'(cnt), 0);
      in_valid = 1; in_sub = 1; in_cin = 0; a16 = 16'h0009; b16 = 16'h0004;
      step();
      in_valid = 0;
      wait_valid(n);
      chk("post_reset_latency", 32'(n), 3);
      chk("post_reset_q", 32'(q0), 32'h05);

      // randomized traffic with random stalls, bubbles and occasional resets
      for (int i = 0; i < 800; i++) begin
         ce       = ($urandom % 5) != 0;
         in_valid = ($urandom % 4) != 0;
         rst_n    = ($urandom % 100) != 0;
         in_sub   = 1'($urandom); in_cin = 1'($urandom);
         a16 = 16'($urandom); b16 = 16'($urandom);
         step();
      end
      rst_n = 1; ce = 1; in_valid = 0;
      repeat (20) step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
